// File: rtl/alu_pkg.sv
// alu_pkg: shared constants and FSM state type for the ALU issue controller.
package alu_pkg;

  // 3-bit ALU select encodings
  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_SLT  = 3'd4;
  localparam logic [2:0] ALU_MUL  = 3'd5;
  localparam logic [2:0] ALU_DIV  = 3'd6;
  localparam logic [2:0] ALU_PASS = 3'd7;

  // R-type funct field encodings
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_MUL  = 6'h18;
  localparam logic [5:0] FUNCT_DIV  = 6'h1A;
  localparam logic [5:0] FUNCT_PASS = 6'h00;

  // Issue controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/alu_funct_decode.sv
// alu_funct_decode: combinational R-type funct to ALU select decoder.
// Flags unknown functs and the long-latency (mul/div) operations.
module alu_funct_decode
  import alu_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] sel,
  output logic       known,
  output logic       is_muldiv
);

  // Map funct onto the ALU select; anything unlisted is unknown
  always_comb begin
    sel       = ALU_ADD;
    known     = 1'b1;
    is_muldiv = 1'b0;
    case (funct)
      FUNCT_ADD:  sel = ALU_ADD;
      FUNCT_SUB:  sel = ALU_SUB;
      FUNCT_AND:  sel = ALU_AND;
      FUNCT_OR:   sel = ALU_OR;
      FUNCT_SLT:  sel = ALU_SLT;
      FUNCT_MUL: begin
        sel       = ALU_MUL;
        is_muldiv = 1'b1;
      end
      FUNCT_DIV: begin
        sel       = ALU_DIV;
        is_muldiv = 1'b1;
      end
      FUNCT_PASS: sel = ALU_PASS;
      default: begin
        sel   = ALU_ADD;
        known = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: accepts R-type requests, drives the combinational ALU with
// registered operands/select for the needed settle time, and returns the
// captured result on a valid/ready response port.
// Optional feature: ALU_DIVZERO_CHECK_EN -- when defined, a divide with a zero
// divisor is not issued and is answered immediately with an error response.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int MULDIV_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_funct,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_s,
  input  logic [31:0] alu_z,
  input  logic        alu_zf,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_z,
  output logic        out_zf,
  output logic        out_err
);

  // Counter preload: ISSUE is the first held cycle, WAIT runs down to 0
  localparam logic [3:0] WAIT_LOAD  = 4'(MULDIV_WAIT - 2);
  localparam bit         MULTI_WAIT = (MULDIV_WAIT > 1);

  state_e      state_r, state_nxt_s;
  logic [3:0]  cnt_r, cnt_nxt_s;
  logic        muldiv_r, muldiv_nxt_s;
  logic [31:0] alu_a_r, alu_a_nxt_s;
  logic [31:0] alu_b_r, alu_b_nxt_s;
  logic [2:0]  alu_s_r, alu_s_nxt_s;
  logic [31:0] out_z_r, out_z_nxt_s;
  logic        out_zf_r, out_zf_nxt_s;
  logic        out_err_r, out_err_nxt_s;

  logic [2:0]  dec_sel_s;
  logic        dec_known_s;
  logic        dec_muldiv_s;
  logic        divz_s;

  alu_funct_decode u_decode (
    .funct     (in_funct),
    .sel       (dec_sel_s),
    .known     (dec_known_s),
    .is_muldiv (dec_muldiv_s)
  );

`ifdef ALU_DIVZERO_CHECK_EN
  assign divz_s = (in_funct == FUNCT_DIV) && (in_b == 32'd0);
`else
  assign divz_s = 1'b0;
`endif

  // Next-state and next-register values for the issue FSM
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    muldiv_nxt_s  = muldiv_r;
    alu_a_nxt_s   = alu_a_r;
    alu_b_nxt_s   = alu_b_r;
    alu_s_nxt_s   = alu_s_r;
    out_z_nxt_s   = out_z_r;
    out_zf_nxt_s  = out_zf_r;
    out_err_nxt_s = out_err_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          if (dec_known_s && !divz_s) begin
            alu_a_nxt_s  = in_a;
            alu_b_nxt_s  = in_b;
            alu_s_nxt_s  = dec_sel_s;
            muldiv_nxt_s = dec_muldiv_s;
            state_nxt_s  = ST_ISSUE;
          end else begin
            // Not issued: ALU port keeps its last values
            out_z_nxt_s   = divz_s ? 32'hFFFF_FFFF : 32'd0;
            out_zf_nxt_s  = 1'b0;
            out_err_nxt_s = 1'b1;
            state_nxt_s   = ST_RESP;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (muldiv_r && MULTI_WAIT) begin
          cnt_nxt_s   = WAIT_LOAD;
          state_nxt_s = ST_WAIT;
        end else begin
          out_z_nxt_s   = alu_z;
          out_zf_nxt_s  = alu_zf;
          out_err_nxt_s = 1'b0;
          state_nxt_s   = ST_RESP;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) begin
          out_z_nxt_s   = alu_z;
          out_zf_nxt_s  = alu_zf;
          out_err_nxt_s = 1'b0;
          state_nxt_s   = ST_RESP;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      ST_RESP: begin
        if (out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 4'd0;
      muldiv_r  <= 1'b0;
      alu_a_r   <= 32'd0;
      alu_b_r   <= 32'd0;
      alu_s_r   <= 3'd0;
      out_z_r   <= 32'd0;
      out_zf_r  <= 1'b0;
      out_err_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      muldiv_r  <= muldiv_nxt_s;
      alu_a_r   <= alu_a_nxt_s;
      alu_b_r   <= alu_b_nxt_s;
      alu_s_r   <= alu_s_nxt_s;
      out_z_r   <= out_z_nxt_s;
      out_zf_r  <= out_zf_nxt_s;
      out_err_r <= out_err_nxt_s;
    end
  end

  assign in_ready  = (state_r == ST_IDLE) && !rst;
  assign out_valid = (state_r == ST_RESP);
  assign alu_a     = alu_a_r;
  assign alu_b     = alu_b_r;
  assign alu_s     = alu_s_r;
  assign out_z     = out_z_r;
  assign out_zf    = out_zf_r;
  assign out_err   = out_err_r;

endmodule
